// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_P0 = 2'b01;
    localparam logic [1:0] GNT_P1 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester and memory-side signal bundle of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    // Arbiter side.
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_dout,
        output p0_ack, p1_ack, rdata, gnt,
        output mem_addr, mem_din, mem_we
    );

    // Requesters plus memory model side.
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_dout,
        input  p0_ack, p1_ack, rdata, gnt,
        input  mem_addr, mem_din, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker, one-hot result.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic      [1:0] win
);
    // last = 1 means port 1 won most recently, so port 0 wins a tie.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = GNT_P0;
            2'b10:   win = GNT_P1;
            2'b11:   win = last ? GNT_P0 : GNT_P1;
            default: win = 2'b00;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port memory between two
//               requesters; three cycles per transaction, one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)(
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);
    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic          r_we_q;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_gnt;
    logic [1:0]    w_win;

    rr_pick2 u_pick (
        .req  ({bus.p1_req, bus.p0_req}),
        .last (r_last),
        .win  (w_win)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (|w_win) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only when a grant is made from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_we_q  <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rdata <= '0;
            r_gnt   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_win) begin
                        if (w_win[1]) begin
                            r_we_q <= bus.p1_we;
                            r_addr <= bus.p1_addr;
                            r_din  <= bus.p1_wdata;
                        end else begin
                            r_we_q <= bus.p0_we;
                            r_addr <= bus.p0_addr;
                            r_din  <= bus.p0_wdata;
                        end
                        r_gnt  <= w_win;
                        r_last <= w_win[1];
                    end
                end
                ST_ACCESS: r_rdata <= bus.mem_dout;
                ST_DONE:   r_gnt   <= 2'b00;
                default:   r_gnt   <= 2'b00;
            endcase
        end
    end

    // Reset masks write and ack immediately so an aborted access leaves no trace.
    assign bus.mem_we   = (r_state == ST_ACCESS) & r_we_q & ~rst;
    assign bus.p0_ack   = (r_state == ST_DONE) & r_gnt[0] & ~rst;
    assign bus.p1_ack   = (r_state == ST_DONE) & r_gnt[1] & ~rst;
    assign bus.mem_addr = r_addr;
    assign bus.mem_din  = r_din;
    assign bus.rdata    = r_rdata;
    assign bus.gnt      = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if mif ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(mif));

    always #5 clk = ~clk;

    // Memory model: clocked write, combinational read.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    always @(posedge clk) if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_din;
    assign mif.mem_dout = mem[mif.mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endfunction

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference: a grant is decided whenever the shared memory is free, each
    // transaction occupies exactly three clock edges, ties go to the port
    // that did not win last.
    int         cyc      = 0;
    bit         m_active = 0;
    int         m_start  = 0;
    bit         m_port   = 0;
    bit         m_we     = 0;
    logic [7:0] m_addr   = 0;
    logic [7:0] m_wdata  = 0;
    logic [7:0] m_rdata  = 0;
    bit         m_last   = 1;

    initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            m_active = 0;
            m_last   = 1;
            m_addr   = 0;
            m_wdata  = 0;
            m_rdata  = 0;
        end else if (m_active && cyc == m_start + 1) begin
            m_rdata = ref_mem[m_addr];
            if (m_we) ref_mem[m_addr] = m_wdata;
        end else if (m_active && cyc == m_start + 2) begin
            m_active = 0;
        end else if (!m_active && (mif.p0_req || mif.p1_req)) begin
            if (mif.p0_req && mif.p1_req) m_port = !m_last;
            else                          m_port = mif.p1_req;
            m_last = m_port;
            if (m_port) begin
                m_we = mif.p1_we; m_addr = mif.p1_addr; m_wdata = mif.p1_wdata;
            end else begin
                m_we = mif.p0_we; m_addr = mif.p0_addr; m_wdata = mif.p0_wdata;
            end
            m_active = 1;
            m_start  = cyc;
            sb.push_back(exp_t'{port: m_port, data: ref_mem[m_addr]});
        end
    end

    // Monitor: cycle-level output checks plus scoreboard pop on every ack.
    logic [1:0] exp_gnt;
    logic [1:0] exp_ack;
    exp_t       got;
    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_gnt = m_active ? (m_port ? 2'b10 : 2'b01) : 2'b00;
            exp_ack = (m_active && cyc == m_start + 1 && !rst) ? exp_gnt : 2'b00;
            chk("gnt", 32'(mif.gnt), 32'(exp_gnt));
            chk("ack", 32'({mif.p1_ack, mif.p0_ack}), 32'(exp_ack));
            chk("mem_we", 32'(mif.mem_we), 32'(m_active && cyc == m_start && m_we && !rst));
            chk("rdata_hold", 32'(mif.rdata), 32'(m_rdata));
            chk("mem_addr", 32'(mif.mem_addr), 32'(m_addr));
            chk("mem_din", 32'(mif.mem_din), 32'(m_wdata));
            if (mif.p0_ack || mif.p1_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'({mif.p1_ack, mif.p0_ack}), 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("ack_port", 32'(mif.p1_ack), 32'(got.port));
                    chk("sb_rdata", 32'(mif.rdata), 32'(got.data));
                end
            end
        end
    end

    task automatic drive(input bit p, input bit req, input bit we,
                         input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            mif.p1_req = req; mif.p1_we = we; mif.p1_addr = a; mif.p1_wdata = d;
        end else begin
            mif.p0_req = req; mif.p0_we = we; mif.p0_addr = a; mif.p0_wdata = d;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic txn(input bit p, input bit we, input logic [7:0] a,
                       input logic [7:0] d, input bit keep, input bit glitch);
        bit seen;
        seen = 0;
        drive(p, 1'b1, we, a, d);
        if (glitch) begin
            @(posedge clk); #1;
            drive(p, 1'b1, we, ~a, ~d);
            @(posedge clk); #1;
            drive(p, 1'b1, we, a, d);
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (p ? mif.p1_ack : mif.p0_ack) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", p);
        end
        @(posedge clk); #1;
        if (!keep) drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read on port 0.
        txn(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);

        // Reset in the ACCESS cycle of a write: no commit, no ack.
        drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h77);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);

        // Contention after a reset: port 0 first.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
            txn(1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0);
        join

        // Saturation: both ports back-to-back.
        fork
            for (int i = 0; i < 4; i++) txn(1'b0, 1'b1, 8'(8'h50 + i), 8'($urandom), i < 3, 1'b0);
            for (int i = 0; i < 4; i++) txn(1'b1, 1'b0, 8'(8'h50 + i), 8'h00, i < 3, 1'b0);
        join

        // Boundary addresses.
        txn(1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Back-to-back on port 0 with inputs disturbed during ACCESS.
        txn(1'b0, 1'b1, 8'h30, 8'h11, 1'b1, 1'b1);
        txn(1'b0, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0);

        // Random traffic from both ports.
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                txn(1'b0, 1'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom), 1'b0);
            end
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                txn(1'b1, 1'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom), 1'b0);
            end
        join
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        repeat (10) @(posedge clk);
        #1 chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
